// File: rtl/ds_operand_collect_pkg.sv
// Shared defaults, FSM encoding and forwarding-bus slice macro for the decode-stage operand collector.
// Pure definitions: no logic, no latency, no flow control.
`define DS_FWD_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package ds_operand_collect_pkg;
    localparam int DS_DATA_W    = 32;
    localparam int DS_REG_AW    = 5;
    localparam int DS_PAYLOAD_W = 64;
    localparam int DS_NUM_FWD   = 3;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
endpackage

// File: rtl/ds_fwd_select.sv
// Per-operand source selection: youngest matching forwarding source wins, otherwise the regfile.
// Purely combinational, zero latency; a matching source whose result is not final marks the operand unresolved.
module ds_fwd_select #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_AW-1:0]         reg_num,
    input  logic                      use_reg,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_data_ok,
    input  logic [DATA_W-1:0]         rf_data,
    output logic                      hit,
    output logic                      resolved,
    output logic [DATA_W-1:0]         value
);

    always_comb begin
        hit      = 1'b0;
        resolved = 1'b1;
        value    = '0;
        if (use_reg && (reg_num != '0)) begin
            for (int i = 0; i < NUM_FWD; i++) begin
                // A pending younger producer shadows any older copy of the register.
                if (!hit && fwd_valid[i] &&
                    (`DS_FWD_SLICE(fwd_dest, i, REG_AW) == reg_num)) begin
                    hit      = 1'b1;
                    resolved = fwd_data_ok[i];
                    value    = fwd_data_ok[i] ? `DS_FWD_SLICE(fwd_data, i, DATA_W) : '0;
                end
            end
            if (!hit) begin
                value = rf_data;
            end
        end
    end

endmodule

// File: rtl/ds_operand_collect.sv
// Decode-stage operand collector: holds one instruction, resolves rs/rt via forwarding/regfile, offers it to execute.
// Latency: out_valid the cycle after accept if no hazard; backpressure via out_allowin, operands locked while held.
// Optional DS_STALL_CNT_EN adds a saturating stall_cnt output counting opnd_stall cycles.
module ds_operand_collect
    import ds_operand_collect_pkg::*;
#(
    parameter int DATA_W    = DS_DATA_W,
    parameter int REG_AW    = DS_REG_AW,
    parameter int NUM_FWD   = DS_NUM_FWD,
    parameter int PAYLOAD_W = DS_PAYLOAD_W
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_allowin,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [REG_AW-1:0]         in_rs,
    input  logic [REG_AW-1:0]         in_rt,
    input  logic                      in_rs_use,
    input  logic                      in_rt_use,
    output logic [REG_AW-1:0]         rf_raddr1,
    output logic [REG_AW-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_data_ok,
    output logic                      out_valid,
    input  logic                      out_allowin,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [DATA_W-1:0]         out_rs_value,
    output logic [DATA_W-1:0]         out_rt_value,
    output logic                      opnd_stall
`ifdef DS_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    logic [1:0]           state;
    logic [PAYLOAD_W-1:0] pl_q;
    logic [REG_AW-1:0]    rs_q, rt_q;
    logic                 rs_use_q, rt_use_q;
    logic                 rs_lock, rt_lock;
    logic [DATA_W-1:0]    rs_val_q, rt_val_q;

    logic                 sel_rs_res, sel_rt_res;
    logic [DATA_W-1:0]    sel_rs_val, sel_rt_val;
    logic                 unused_rs_hit, unused_rt_hit;

    logic                 rs_res, rt_res;
    logic                 held, handshake, accept;

    ds_fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel_rs (
        .reg_num     (rs_q),
        .use_reg     (rs_use_q),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data),
        .fwd_data_ok (fwd_data_ok),
        .rf_data     (rf_rdata1),
        .hit         (unused_rs_hit),
        .resolved    (sel_rs_res),
        .value       (sel_rs_val)
    );

    ds_fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel_rt (
        .reg_num     (rt_q),
        .use_reg     (rt_use_q),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data),
        .fwd_data_ok (fwd_data_ok),
        .rf_data     (rf_rdata2),
        .hit         (unused_rt_hit),
        .resolved    (sel_rt_res),
        .value       (sel_rt_val)
    );

    assign rf_raddr1    = rs_q;
    assign rf_raddr2    = rt_q;

    assign rs_res       = rs_lock | sel_rs_res;
    assign rt_res       = rt_lock | sel_rt_res;
    assign out_rs_value = rs_lock ? rs_val_q : sel_rs_val;
    assign out_rt_value = rt_lock ? rt_val_q : sel_rt_val;
    assign out_payload  = pl_q;

    assign held         = (state != ST_EMPTY);
    assign out_valid    = held & rs_res & rt_res;
    assign opnd_stall   = held & ~out_valid;
    assign handshake    = out_valid & out_allowin;
    assign in_allowin   = (state == ST_EMPTY) | handshake;
    assign accept       = in_valid & in_allowin & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_EMPTY;
            pl_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rs_use_q <= 1'b0;
            rt_use_q <= 1'b0;
            rs_lock  <= 1'b0;
            rt_lock  <= 1'b0;
            rs_val_q <= '0;
            rt_val_q <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            rs_lock <= 1'b0;
            rt_lock <= 1'b0;
        end else if (accept) begin
            state    <= ST_WAIT;
            pl_q     <= in_payload;
            rs_q     <= in_rs;
            rt_q     <= in_rt;
            rs_use_q <= in_rs_use;
            rt_use_q <= in_rt_use;
            rs_lock  <= 1'b0;
            rt_lock  <= 1'b0;
        end else if (handshake) begin
            state   <= ST_EMPTY;
            rs_lock <= 1'b0;
            rt_lock <= 1'b0;
        end else if (held) begin
            // Freeze resolved operands so they survive the producer retiring or changing.
            if (sel_rs_res && !rs_lock) begin
                rs_lock  <= 1'b1;
                rs_val_q <= sel_rs_val;
            end
            if (sel_rt_res && !rt_lock) begin
                rt_lock  <= 1'b1;
                rt_val_q <= sel_rt_val;
            end
            state <= (rs_res && rt_res) ? ST_READY : ST_WAIT;
        end
    end

`ifdef DS_STALL_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (opnd_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ds_operand_collect.sv
// Directed bench for ds_operand_collect: vector table plus hand-written multi-cycle sequences.
module tb_ds_operand_collect;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_allowin;
    logic [63:0] in_payload;
    logic [4:0]  in_rs, in_rt;
    logic        in_rs_use, in_rt_use;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [2:0]  fwd_valid;
    logic [14:0] fwd_dest;
    logic [95:0] fwd_data;
    logic [2:0]  fwd_data_ok;
    logic        out_valid;
    logic        out_allowin;
    logic [63:0] out_payload;
    logic [31:0] out_rs_value, out_rt_value;
    logic        opnd_stall;
`ifdef DS_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] cnt0;
`endif

    logic [31:0] rf_mem [32];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    always #5 clk = ~clk;

    ds_operand_collect dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_allowin   (in_allowin),
        .in_payload   (in_payload),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rs_use    (in_rs_use),
        .in_rt_use    (in_rt_use),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .fwd_valid    (fwd_valid),
        .fwd_dest     (fwd_dest),
        .fwd_data     (fwd_data),
        .fwd_data_ok  (fwd_data_ok),
        .out_valid    (out_valid),
        .out_allowin  (out_allowin),
        .out_payload  (out_payload),
        .out_rs_value (out_rs_value),
        .out_rt_value (out_rt_value),
        .opnd_stall   (opnd_stall)
`ifdef DS_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic        rs_use, rt_use;
        logic [2:0]  fv;
        logic [4:0]  fd0, fd1, fd2;
        logic [31:0] fx0, fx1, fx2;
        logic [2:0]  fok;
        logic        exp_vld;
        logic [31:0] exp_rs, exp_rt;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int n_applied = 0;
    int n_err     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_fwd(input int i, input logic v, input logic [4:0] d,
                           input logic [31:0] x, input logic ok);
        fwd_valid[i]           = v;
        fwd_dest[i*5 +: 5]     = d;
        fwd_data[i*32 +: 32]   = x;
        fwd_data_ok[i]         = ok;
    endtask

    task automatic clr_fwd();
        fwd_valid   = '0;
        fwd_dest    = '0;
        fwd_data    = '0;
        fwd_data_ok = '0;
    endtask

    task automatic drive_in(input logic [4:0] rs, input logic [4:0] rt,
                            input logic rsu, input logic rtu, input logic [63:0] pl);
        in_valid   = 1'b1;
        in_rs      = rs;
        in_rt      = rt;
        in_rs_use  = rsu;
        in_rt_use  = rtu;
        in_payload = pl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000 + r;
        rf_mem[3] = 32'h11;
        rf_mem[4] = 32'h22;

        vecs[0] = '{5'd3, 5'd4, 1'b1, 1'b1, 3'b000, 5'd0, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h11, 32'h22};
        vecs[1] = '{5'd5, 5'd6, 1'b1, 1'b1, 3'b101, 5'd5, 5'd0, 5'd5,
                    32'hAAAA, 32'h0, 32'hBBBB, 3'b111, 1'b1, 32'hAAAA, 32'h1006};
        vecs[2] = '{5'd0, 5'd5, 1'b1, 1'b1, 3'b001, 5'd0, 5'd0, 5'd0,
                    32'hDEAD, 32'h0, 32'h0, 3'b111, 1'b1, 32'h0, 32'h1005};
        vecs[3] = '{5'd7, 5'd8, 1'b0, 1'b0, 3'b011, 5'd7, 5'd7, 5'd0,
                    32'h0, 32'h77, 32'h0, 3'b000, 1'b1, 32'h0, 32'h0};
        vecs[4] = '{5'd7, 5'd9, 1'b1, 1'b1, 3'b011, 5'd7, 5'd7, 5'd0,
                    32'h0, 32'h77, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{5'd2, 5'd2, 1'b1, 1'b1, 3'b100, 5'd0, 5'd0, 5'd2,
                    32'h0, 32'h0, 32'hCC, 3'b100, 1'b1, 32'hCC, 32'hCC};
        vecs[6] = '{5'd1, 5'd6, 1'b1, 1'b1, 3'b011, 5'd9, 5'd6, 5'd0,
                    32'h99, 32'h66, 32'h0, 3'b011, 1'b1, 32'h1001, 32'h66};
        vecs[7] = '{5'd4, 5'd0, 1'b1, 1'b1, 3'b110, 5'd0, 5'd4, 5'd4,
                    32'h0, 32'h44, 32'hBB, 3'b010, 1'b1, 32'h44, 32'h0};
        vecs[8] = '{5'd9, 5'd9, 1'b1, 1'b1, 3'b010, 5'd9, 5'd3, 5'd0,
                    32'hEE, 32'h33, 32'h0, 3'b111, 1'b1, 32'h1009, 32'h1009};

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b1;
        in_payload = '0; in_rs = '0; in_rt = '0; in_rs_use = 1'b0; in_rt_use = 1'b0;
        clr_fwd();
        #12;
        chk("rst_in_allowin", in_allowin, 1);
        chk("rst_out_valid",  out_valid, 0);
        chk("rst_opnd_stall", opnd_stall, 0);
        chk("rst_payload",    out_payload, 0);
        chk("rst_rs_value",   out_rs_value, 0);
        resetn = 1'b1;
        step();

        // Table: one instruction per vector, checked the cycle after accept.
        for (int i = 0; i < NV; i++) begin
            drive_in(vecs[i].rs, vecs[i].rt, vecs[i].rs_use, vecs[i].rt_use, 64'hC0DE_0000 + i);
            set_fwd(0, vecs[i].fv[0], vecs[i].fd0, vecs[i].fx0, vecs[i].fok[0]);
            set_fwd(1, vecs[i].fv[1], vecs[i].fd1, vecs[i].fx1, vecs[i].fok[1]);
            set_fwd(2, vecs[i].fv[2], vecs[i].fd2, vecs[i].fx2, vecs[i].fok[2]);
            out_allowin = 1'b1;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_vld);
            chk($sformatf("v%0d_opnd_stall", i), opnd_stall, !vecs[i].exp_vld);
            chk($sformatf("v%0d_payload", i), out_payload, 64'hC0DE_0000 + i);
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d_rs", i), out_rs_value, vecs[i].exp_rs);
                chk($sformatf("v%0d_rt", i), out_rt_value, vecs[i].exp_rt);
            end
            flush = !vecs[i].exp_vld;
            step();
            flush = 1'b0;
            clr_fwd();
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Back-to-back: accept while handing off, no bubble.
        drive_in(5'd3, 5'd4, 1'b1, 1'b1, 64'hA);
        step();
        drive_in(5'd4, 5'd3, 1'b1, 1'b1, 64'hB);
        @(negedge clk);
        chk("b2b_a_valid",    out_valid, 1);
        chk("b2b_a_allowin",  in_allowin, 1);
        chk("b2b_a_payload",  out_payload, 64'hA);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_b_valid",    out_valid, 1);
        chk("b2b_b_payload",  out_payload, 64'hB);
        chk("b2b_b_rs",       out_rs_value, 32'h22);
        chk("b2b_b_rt",       out_rt_value, 32'h11);
        step();
        chk("b2b_empty",      out_valid, 0);

        // Load-use: fwd0 pending on r7 shadows fwd1's r7 for two cycles.
        set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
        set_fwd(1, 1'b1, 5'd7, 32'h99, 1'b1);
        drive_in(5'd7, 5'd0, 1'b1, 1'b0, 64'h10AD);
`ifdef DS_STALL_CNT_EN
        cnt0 = stall_cnt;
`endif
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("lu_stall%0d", c), opnd_stall, 1);
            chk($sformatf("lu_novalid%0d", c), out_valid, 0);
            if (c == 0) begin
                out_allowin = 1'b0;
                step();
                out_allowin = 1'b1;
            end
        end
        step();
        set_fwd(0, 1'b1, 5'd7, 32'h1234, 1'b1);
        @(negedge clk);
        chk("lu_valid",  out_valid, 1);
        chk("lu_rs",     out_rs_value, 32'h1234);
`ifdef DS_STALL_CNT_EN
        chk("lu_stall_cnt", stall_cnt, cnt0 + 32'd2);
`endif
        step();
        clr_fwd();
        chk("lu_empty",  out_valid, 0);

        // Lock under backpressure: rt captured from fwd1 survives source change.
        out_allowin = 1'b0;
        set_fwd(1, 1'b1, 5'd6, 32'h55, 1'b1);
        drive_in(5'd0, 5'd6, 1'b0, 1'b1, 64'h10CC);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lk_valid0", out_valid, 1);
        chk("lk_rt0",    out_rt_value, 32'h55);
        step();
        set_fwd(1, 1'b0, 5'd6, 32'h66, 1'b1);
        @(negedge clk);
        chk("lk_valid1", out_valid, 1);
        chk("lk_rt1",    out_rt_value, 32'h55);
        chk("lk_payload", out_payload, 64'h10CC);
        step();
        @(negedge clk);
        chk("lk_rt2",    out_rt_value, 32'h55);
        out_allowin = 1'b1;
        step();
        clr_fwd();
        chk("lk_empty",  out_valid, 0);

        // Flush with simultaneous in_valid while in WAIT.
        set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
        drive_in(5'd7, 5'd0, 1'b1, 1'b0, 64'hF1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_wait", opnd_stall, 1);
`ifdef DS_STALL_CNT_EN
        cnt0 = stall_cnt;
`endif
        step();
        flush = 1'b1;
        drive_in(5'd3, 5'd4, 1'b1, 1'b1, 64'hF2);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_stall",     opnd_stall, 0);
        chk("fl_allowin",   in_allowin, 1);
`ifdef DS_STALL_CNT_EN
        chk("fl_cnt_kept",  stall_cnt, cnt0 + 32'd2);
`endif

        // Asynchronous reset mid-WAIT.
        step();
        drive_in(5'd7, 5'd0, 1'b1, 1'b0, 64'hE7);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_wait", opnd_stall, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_stall",     opnd_stall, 0);
        chk("ar_allowin",   in_allowin, 1);
        chk("ar_payload",   out_payload, 0);
`ifdef DS_STALL_CNT_EN
        chk("ar_cnt",       stall_cnt, 0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        clr_fwd();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

endmodule

// File: doc/ds_operand_collect.md
Name: ds_operand_collect

Overview:
Parametrised decode-stage operand collector: the next-generation replacement for the fixed 3-source bypass and load-only stall in the decode stage. It holds one decoded instruction, resolves rs/rt from the regfile or from NUM_FWD forwarding sources with per-source data-ready flags, latches operands once they are resolved, and releases the instruction to the execute stage under valid/allowin handshakes. It sits between the fetch-to-decode register and the execute stage. Branch resolution stays outside this block and uses the forwarded values and the stall flag.

Parameters:
DATA_W, 32, operand width
REG_AW, 5, register address width
NUM_FWD, 3, forwarding sources; index 0 is youngest (EX), NUM_FWD-1 is oldest (WB)
PAYLOAD_W, 64, opaque decoded-instruction payload carried through unchanged

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
flush  in  1  discard held instruction
in_valid  in  1  upstream instruction valid
in_allowin  out  1  block can accept this cycle
in_payload  in  PAYLOAD_W  decoded instruction payload
in_rs / in_rt  in  REG_AW  source register numbers
in_rs_use / in_rt_use  in  1  instruction actually reads rs / rt
rf_raddr1 / rf_raddr2  out  REG_AW  regfile read addresses = held rs / rt
rf_rdata1 / rf_rdata2  in  DATA_W  regfile read data (combinational read)
fwd_valid  in  NUM_FWD  source i holds a valid register-writing instruction
fwd_dest  in  NUM_FWD*REG_AW  destination of source i, slice i
fwd_data  in  NUM_FWD*DATA_W  result of source i
fwd_data_ok  in  NUM_FWD  result of source i is final (0 for a load in EX, or a multi-cycle op)
out_valid  out  1  operands resolved, instruction offered
out_allowin  in  1  execute stage accepts
out_payload  out  PAYLOAD_W  held payload
out_rs_value / out_rt_value  out  DATA_W  resolved operands
opnd_stall  out  1  held instruction is valid and at least one operand is unresolved

Behaviour:
- States: EMPTY, WAIT (valid, an operand is unresolved), READY (valid, all operands resolved). Reset and flush go to EMPTY.
- Reset (async, resetn=0): state EMPTY, lock flags 0, out_valid 0, opnd_stall 0, in_allowin 1, stored payload/operands 0.
- in_allowin = (state==EMPTY) | (out_valid & out_allowin). Accept happens when in_valid & in_allowin & ~flush. On accept, capture payload, rs/rt and use flags, and clear the lock flags.
- Per-operand resolution, combinational from the held state:
  - Operand is resolved if it is locked, or the use flag is 0, or the register is 0.
  - Otherwise search sources from 0 upward. The first i with fwd_valid[i] & fwd_dest[i]==reg & fwd_dest[i]!=0 wins.
  - If the winner has fwd_data_ok=1, take fwd_data[i]. If it has fwd_data_ok=0, the operand is unresolved; do not fall through to older sources.
  - If there is no match, take rf_rdataN.
  - Unused or r0 operands output 0.
- Each cycle in WAIT or READY without a handshake, every resolved-but-unlocked operand's value is written to its operand register and its lock flag is set. From then on the value is independent of the forwarding sources.
- out_valid = state!=EMPTY & both operands resolved. opnd_stall = state!=EMPTY & ~out_valid.
- Latency: an instruction with no hazard is accepted on edge N and out_valid is 1 after edge N. A pending-source stall adds one cycle per cycle that fwd_data_ok stays 0.
- Simultaneous out handshake and new accept: the new instruction replaces the old one, with lock flags cleared. No bubble.
- flush takes priority over everything: the held instruction is dropped, any same-cycle in_valid is ignored, and the state is EMPTY after the edge.
- Handshake stability: while out_valid=1 and out_allowin=0, out_payload and the out_*_value outputs remain stable, guaranteed by locking.

Optional Feature:
DS_STALL_CNT_EN: when defined, adds output stall_cnt[31:0]. It increments each cycle opnd_stall=1, saturates at 0xFFFFFFFF, and is reset to 0 by resetn only (flush does not clear it). When undefined, the port and the counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header: DATA_W, REG_AW and PAYLOAD_W defaults, the state encoding (EMPTY=2'd0, WAIT=2'd1, READY=2'd2), and the fwd slice macros.
- Sub-module ds_fwd_select (instanced twice, once per operand):
  - Inputs: reg number, use flag, NUM_FWD source vectors, rf data.
  - Outputs: hit, resolved, value.
  - Purely combinational priority search.

Test Plan:
- No hazard: accept rs=3, rt=4 with rf data 0x11/0x22 → out_valid after 1 edge with values 0x11/0x22. Back-to-back accepts under out_allowin=1 → one instruction per cycle.
- Priority: fwd0 and fwd2 both write r5 (0xAAAA, 0xBBBB), all ok → rs value 0xAAAA. With r0 as the source and fwd0 dest=0 → value 0.
- Load-use: fwd0 dest=r7 with data_ok=0 for 2 cycles, and the fwd1 dest=r7 value is present → opnd_stall=1 for 2 cycles and fwd1 is not used. When data_ok=1 with data 0x1234 → out_valid with 0x1234.
- Lock under backpressure: resolve rt from fwd1=0x55, hold out_allowin=0, then change fwd1 to 0x66 and clear fwd_valid → out_rt_value stays 0x55 until accepted.
- Flush/reset: flush asserted together with in_valid while in WAIT → EMPTY and out_valid=0 next cycle. resetn pulse mid-WAIT → all outputs at reset values immediately (async).
- DS_STALL_CNT_EN: a 3-cycle stall followed by 1 ready cycle → stall_cnt=3. A flush does not clear it.
